mic_spi_capture: RTL and testbench
==================================

Name: mic_spi_capture

Overview:
- Front-end ADC interface for the audio level path. Drives the 3-wire SPI link to the Pmod MIC ADC (ADCS7476-class, 16-bit frame: 4 leading zeros, then D11..D0, MSB first).
- Produces one 12-bit unsigned sample per conversion period (20 kHz at a 100 MHz CLK).
- Feeds the peak-hold/LED level indicator directly downstream through sample and sample_valid.

Parameters:
- CLK_DIV, 25, SCLK half-period in CLK cycles (2 MHz SCLK at 100 MHz); must be >= 1.
- SAMPLE_PERIOD, 5000, CLK cycles between conversion starts (20 kHz); must be > 32*CLK_DIV+2.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RST  in  1  reset; asynchronous assertion, active-high.
- miso  in  1  ADC serial data (Pmod pin 3).
- cs_n  out  1  ADC chip select, active-low (Pmod pin 1).
- sclk  out  1  SPI clock, idles high (Pmod pin 4).
- sample  out  12  last completed conversion, unsigned.
- sample_valid  out  1  one-CLK pulse when sample updates.
- frame_err  out  1  leading-zero check failure flag; see Optional Feature.

Behaviour:
- Reset values (RST high, takes effect immediately): cs_n=1, sclk=1, sample=0, sample_valid=0, frame_err=0, state=IDLE, period timer=0, divider=0, bit count=0, shift register=0.
- A reset asserted mid-frame aborts the transfer: cs_n rises immediately and sample is not updated.
- Period timer: free-running counter 0..SAMPLE_PERIOD-1 that wraps to 0. It keeps counting in every state.
- State IDLE:
  - On the CLK edge where timer==SAMPLE_PERIOD-1, go to SETUP and drive cs_n<=0. Call this edge E0.
  - A wrap that occurs while not in IDLE is dropped. It is not queued.
- State SETUP: holds for CLK_DIV cycles with sclk=1. At E0+CLK_DIV, drive sclk<=0 and go to SHIFT.
- State SHIFT:
  - sclk toggles every CLK_DIV cycles.
  - On each 0->1 edge of the registered sclk, at the same CLK edge, shift miso into the LSB of a 16-bit shift register and increment the bit count.
  - The k-th rising edge (k=1..16) falls at E0+2k*CLK_DIV.
  - After the 16th rising edge at E0+32*CLK_DIV, sclk stays high and the state goes to DONE.
- State DONE (single cycle, edge E0+32*CLK_DIV+1):
  - cs_n<=1, sample<=shift[11:0], sample_valid<=1. Return to IDLE.
  - sample_valid deasserts on the next edge.
- Latency: sample_valid rises 32*CLK_DIV+1 cycles after cs_n falls (801 at defaults). cs_n is low for exactly 32*CLK_DIV+1 cycles.
- Rates:
  - sample_valid pulses exactly once per SAMPLE_PERIOD in steady state.
  - The first pulse follows the first timer wrap after reset release (edge SAMPLE_PERIOD-1) plus the latency above.
- Widths:
  - Divider counter is sized for CLK_DIV-1.
  - Bit count is 5 bits and saturates at 16.
  - No arithmetic on the sample data; the value passes through unsigned.
- sample holds its value between pulses; downstream may read it at any time.
- miso is sampled directly. Settling margin is ensured by the half-period CLK_DIV.

Optional Feature:
- Macro: MIC_FRAME_CHECK_EN.
- Defined:
  - In DONE, frame_err<=1 if shift[15:12]!=0, else frame_err<=0. It updates together with sample_valid and holds until the next DONE or reset.
  - sample still updates on an errored frame.
- Undefined: frame_err is tied to 0 and there is no checking logic.

Test Plan:
- Reset then idle: RST high for 5 cycles, then release -> cs_n=1, sclk=1, sample=0, sample_valid=0 until edge 4999. cs_n falls at 4999. First sample_valid pulse at edge 4999+801=5800.
- Single frame: ADC model returns 0000_1010_1100_0011 -> sample=12'hAC3, sample_valid high for exactly 1 cycle. Exactly 16 sclk rising edges while cs_n low. sclk period 50 cycles.
- Full scale and zero: frames 0x0FFF then 0x0000 -> sample=4095, then 0. Pulses 5000 cycles apart.
- Mid-frame reset: assert RST at edge E0+400 -> cs_n=1 and sclk=1 within that cycle, no sample_valid. sample keeps reset value 0. Next frame starts at the next timer wrap after release.
- Frame check with MIC_FRAME_CHECK_EN defined: frame 0x9ABC -> sample=12'hABC, frame_err=1. Next frame 0x0123 -> frame_err=0. Without the macro, frame_err stays 0 throughout.
- Parameter sweep: CLK_DIV=2, SAMPLE_PERIOD=100 -> cs_n low for 65 cycles, sample_valid every 100 cycles. Data matches the model for 10 random frames.

Source files
------------

// File: rtl/mic_spi_capture.sv
// SPI capture front end for the Pmod MIC ADC: one 12-bit sample per SAMPLE_PERIOD.
// Optional leading-zero frame check enabled by defining MIC_FRAME_CHECK_EN.
module mic_spi_capture #(
    parameter int unsigned CLK_DIV       = 25,
    parameter int unsigned SAMPLE_PERIOD = 5000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        miso,
    output logic        cs_n,
    output logic        sclk,
    output logic [11:0] sample,
    output logic        sample_valid,
    output logic        frame_err
);

    localparam int unsigned TIMER_W = $clog2(SAMPLE_PERIOD);
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [DIV_W-1:0]   div;
    logic [4:0]         bit_cnt;
    logic [15:0]        shift;
    logic               wrap;
    logic               div_end;

    assign wrap    = (timer == TIMER_W'(SAMPLE_PERIOD - 1));
    assign div_end = (div == DIV_W'(CLK_DIV - 1));

    // Free-running conversion period timer, independent of the transfer state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timer <= '0;
        end else if (wrap) begin
            timer <= '0;
        end else begin
            timer <= timer + TIMER_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            cs_n         <= 1'b1;
            sclk         <= 1'b1;
            div          <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (wrap) begin
                        state   <= SETUP;
                        cs_n    <= 1'b0;
                        div     <= '0;
                        bit_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        div   <= '0;
                        sclk  <= 1'b0;
                        state <= SHIFT;
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (div_end) begin
                        div  <= '0;
                        sclk <= ~sclk;
                        // Capture on the CLK edge that raises sclk; the 16th rise ends the frame
                        if (!sclk) begin
                            shift   <= {shift[14:0], miso};
                            bit_cnt <= (bit_cnt == 5'd16) ? bit_cnt : bit_cnt + 5'd1;
                            if (bit_cnt == 5'd15) begin
                                state <= DONE;
                            end
                        end
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                DONE: begin
                    cs_n         <= 1'b1;
                    sample       <= shift[11:0];
                    sample_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MIC_FRAME_CHECK_EN
    // Leading four bits of a good frame are zero; flag updates with each sample
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frame_err <= 1'b0;
        end else if (state == DONE) begin
            frame_err <= (shift[15:12] != 4'd0);
        end
    end
`else
    logic unused_lead_bits;
    assign unused_lead_bits = ^shift[15:12];
    assign frame_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mic_spi_capture.sv
// Bench for mic_spi_capture: two instances (default and small parameters) checked
// every cycle against a period/offset model, plus directed literal checks.
module tb_mic_spi_capture;

`ifdef MIC_FRAME_CHECK_EN
    localparam bit FCHK = 1'b1;
`else
    localparam bit FCHK = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic checking = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_n = 0;
    logic [15:0] word_q[$];

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got 0x%0h expected 0x%0h", nm, idx, $time, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL timeout %s at %0t: awaited event never came", nm, $time);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned CD = (g == 0) ? 25 : 2;
        localparam int unsigned SP = (g == 0) ? 5000 : 100;

        logic        miso_i = 1'b0;
        logic        cs_n_i;
        logic        sclk_i;
        logic [11:0] sample_i;
        logic        sample_valid_i;
        logic        frame_err_i;

        logic [15:0] adc_word = '0;
        logic [15:0] adc_frame = '0;

        mic_spi_capture #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP)) dut (
            .CLK(CLK),
            .RST(RST),
            .miso(miso_i),
            .cs_n(cs_n_i),
            .sclk(sclk_i),
            .sample(sample_i),
            .sample_valid(sample_valid_i),
            .frame_err(frame_err_i)
        );

        // ADC: MSB valid at chip-select fall, next bit after each sclk rise
        initial forever begin
            @(negedge cs_n_i);
            adc_frame = adc_word;
            miso_i = adc_frame[15];
            for (int k = 1; k < 16; k++) begin
                @(posedge sclk_i or posedge cs_n_i);
                if (cs_n_i) break;
                miso_i = adc_frame[15 - k];
            end
        end

        // Expected outputs from the edge index since reset release
        int unsigned e = 0;
        int unsigned o = 0;
        logic [15:0] fw = '0;
        logic        x_cs = 1'b1;
        logic        x_sclk = 1'b1;
        logic        x_valid = 1'b0;
        logic        x_err = 1'b0;
        logic [11:0] x_sample = '0;

        always @(posedge CLK or posedge RST) begin
            if (RST) begin
                e = 0; x_cs = 1'b1; x_sclk = 1'b1; x_valid = 1'b0; x_sample = '0; x_err = 1'b0;
            end else begin
                o = (e + 1) % SP;
                x_cs = 1'b1; x_sclk = 1'b1; x_valid = 1'b0;
                if (e + 1 >= SP) begin
                    if (o == 0) begin
                        if (g == 0 && word_q.size() != 0) fw = word_q.pop_front();
                        else fw = 16'($urandom);
                        adc_word = fw;
                    end
                    if (o <= 32 * CD) begin
                        x_cs = 1'b0;
                        x_sclk = ((o / CD) % 2) == 0;
                    end else if (o == 32 * CD + 1) begin
                        x_valid = 1'b1;
                        x_sample = fw[11:0];
                        x_err = FCHK && (fw[15:12] != 4'd0);
                    end
                end
                e++;
            end
        end

        always @(negedge CLK) begin
            if (checking) begin
                check("cs_n", g, 32'(cs_n_i), 32'(x_cs));
                check("sclk", g, 32'(sclk_i), 32'(x_sclk));
                check("sample_valid", g, 32'(sample_valid_i), 32'(x_valid));
                check("sample", g, 32'(sample_i), 32'(x_sample));
                check("frame_err", g, 32'(frame_err_i), 32'(x_err));
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
        edge_n++;
    endtask

    task automatic wait_cs_fall(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            tick();
            if (!g_dut[0].cs_n_i) begin
                ok = 1'b1;
                return;
            end
        end
        timeout(nm);
    endtask

    task automatic wait_valid(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            tick();
            if (g_dut[0].sample_valid_i) begin
                ok = 1'b1;
                return;
            end
        end
        timeout(nm);
    endtask

    // Directed sequence on the default-parameter instance
    initial begin
        bit   ok;
        int   t_prev;
        int   rises;
        int   r1;
        int   r2;
        logic prev_sclk;

        word_q.push_back(16'h0AC3);
        word_q.push_back(16'h0FFF);
        word_q.push_back(16'h0000);
        #1 RST = 1'b1;
        checking = 1'b1;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        check("reset_cs_n", 0, 32'(g_dut[0].cs_n_i), 32'd1);
        check("reset_sample", 0, 32'(g_dut[0].sample_i), 32'd0);
        RST = 1'b0;
        edge_n = -1;

        wait_cs_fall("first_cs_fall", ok);
        check("cs_fall_edge", 0, edge_n, 4999);

        rises = 0; r1 = 0; r2 = 0; prev_sclk = 1'b1; ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            tick();
            if (!g_dut[0].cs_n_i && g_dut[0].sclk_i && !prev_sclk) begin
                rises++;
                if (rises == 1) r1 = edge_n;
                if (rises == 2) r2 = edge_n;
            end
            prev_sclk = g_dut[0].sclk_i;
            if (g_dut[0].sample_valid_i) ok = 1'b1;
        end
        if (!ok) timeout("first_valid");
        check("first_valid_edge", 0, edge_n, 5800);
        check("sclk_rises", 0, rises, 16);
        check("first_rise_edge", 0, r1, 5049);
        check("sclk_period", 0, r2 - r1, 50);
        check("sample_ac3", 0, 32'(g_dut[0].sample_i), 32'h0AC3);
        t_prev = edge_n;
        tick();
        check("valid_width", 0, 32'(g_dut[0].sample_valid_i), 32'd0);

        wait_valid("full_scale", ok);
        check("pulse_spacing", 0, edge_n - t_prev, 5000);
        check("sample_full", 0, 32'(g_dut[0].sample_i), 32'd4095);
        t_prev = edge_n;
        wait_valid("zero", ok);
        check("pulse_spacing2", 0, edge_n - t_prev, 5000);
        check("sample_zero", 0, 32'(g_dut[0].sample_i), 32'd0);

        // Abort a transfer 400 cycles into the frame
        wait_cs_fall("abort_frame", ok);
        repeat (400) @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        check("abort_cs_n", 0, 32'(g_dut[0].cs_n_i), 32'd1);
        check("abort_sclk", 0, 32'(g_dut[0].sclk_i), 32'd1);
        check("abort_valid", 0, 32'(g_dut[0].sample_valid_i), 32'd0);
        check("abort_sample", 0, 32'(g_dut[0].sample_i), 32'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        edge_n = -1;
        word_q.push_back(16'h9ABC);
        word_q.push_back(16'h0123);

        wait_cs_fall("restart_cs_fall", ok);
        check("restart_fall_edge", 0, edge_n, 4999);
        wait_valid("errored_frame", ok);
        check("sample_abc", 0, 32'(g_dut[0].sample_i), 32'h0ABC);
        check("frame_err_set", 0, 32'(g_dut[0].frame_err_i), 32'(FCHK));
        wait_valid("clean_frame", ok);
        check("sample_123", 0, 32'(g_dut[0].sample_i), 32'h0123);
        check("frame_err_clr", 0, 32'(g_dut[0].frame_err_i), 32'd0);

        wait_valid("random_a", ok);
        wait_valid("random_b", ok);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Literal timing checks on the small-parameter instance
    initial begin
        bit ok;
        int low;
        int gap;

        wait (RST == 1'b1);
        wait (RST == 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge CLK);
            if (!g_dut[1].cs_n_i) ok = 1'b1;
        end
        if (!ok) timeout("sweep_cs_fall");
        low = 1; ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge CLK);
            if (g_dut[1].cs_n_i) ok = 1'b1;
            else low++;
        end
        check("sweep_cs_low", 1, low, 65);

        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge CLK);
            if (g_dut[1].sample_valid_i) ok = 1'b1;
        end
        if (!ok) timeout("sweep_valid");
        gap = 0; ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge CLK);
            gap++;
            if (g_dut[1].sample_valid_i) ok = 1'b1;
        end
        check("sweep_valid_gap", 1, gap, 100);
    end

endmodule
